// File: rtl/button_pio_irq_sequencer.sv
// Avalon-MM master for a button PIO: programs irq_mask, services edge interrupts,
// and queues {level, edges} events into a FWFT FIFO with a debounce hold-off.
module button_pio_irq_sequencer #(
  parameter int               WIDTH          = 4,
  parameter int               DEPTH          = 8,
  parameter int               HOLDOFF_CYCLES = 50000,
  parameter logic [WIDTH-1:0] MASK_INIT      = 4'hF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         cfg_mask,
  input  logic                     cfg_mask_wr,
  input  logic                     pio_irq,
  output logic [1:0]               pio_address,
  output logic                     pio_chipselect,
  output logic                     pio_write_n,
  output logic [31:0]              pio_writedata,
  input  logic [31:0]              pio_readdata,
  output logic                     evt_valid,
  output logic [2*WIDTH-1:0]       evt_data,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  typedef enum logic [3:0] {
    INIT_MASK, INIT_CLR, IDLE, CFG, RD_EDGE, RD_EDGE_S,
    CLR, RD_DAT, RD_DAT_S, PUSH, HOLD, HOLD_CLR
  } state_t;

  state_t            state_q, state_d;
  logic              in_reset_q;
  logic [WIDTH-1:0]  mask_q;
  logic              cfg_pend_q;
  logic [WIDTH-1:0]  edges_q;
  logic [WIDTH-1:0]  level_q;
  logic [HW-1:0]     hold_cnt_q;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic               ovf_q;

  logic push_req, full, do_pop, do_push, drop;
  logic unused_rd;

  assign unused_rd = ^pio_readdata[31:WIDTH];

  // in_reset_q keeps the bus idle for the cycle after reset and holds INIT_MASK
  // so the start-up write appears only once reset_n has been released.
  always_comb begin
    state_d        = state_q;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = 2'd0;
    pio_writedata  = '0;
    if (!in_reset_q) begin
      case (state_q)
        INIT_MASK: begin
          pio_chipselect           = 1'b1;
          pio_write_n              = 1'b0;
          pio_address              = 2'd2;
          pio_writedata[WIDTH-1:0] = MASK_INIT;
          state_d                  = INIT_CLR;
        end
        INIT_CLR, CLR, HOLD_CLR: begin
          pio_chipselect           = 1'b1;
          pio_write_n              = 1'b0;
          pio_address              = 2'd3;
          pio_writedata[WIDTH-1:0] = '1;
          state_d                  = (state_q == CLR) ? RD_DAT : IDLE;
        end
        IDLE: begin
          if (cfg_pend_q)              state_d = CFG;
          else if (enable && pio_irq)  state_d = RD_EDGE;
        end
        CFG: begin
          pio_chipselect           = 1'b1;
          pio_write_n              = 1'b0;
          pio_address              = 2'd2;
          pio_writedata[WIDTH-1:0] = mask_q;
          state_d                  = IDLE;
        end
        RD_EDGE, RD_EDGE_S: begin
          pio_chipselect = 1'b1;
          pio_address    = 2'd3;
          state_d        = (state_q == RD_EDGE) ? RD_EDGE_S : CLR;
        end
        RD_DAT, RD_DAT_S: begin
          pio_chipselect = 1'b1;
          pio_address    = 2'd0;
          state_d        = (state_q == RD_DAT) ? RD_DAT_S : PUSH;
        end
        PUSH: begin
          if (edges_q == '0)            state_d = IDLE;
          else if (HOLDOFF_CYCLES > 0)  state_d = HOLD;
          else                          state_d = IDLE;
        end
        HOLD: begin
          if (hold_cnt_q == '0) state_d = HOLD_CLR;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= INIT_MASK;
      in_reset_q <= 1'b1;
      mask_q     <= MASK_INIT;
      cfg_pend_q <= 1'b0;
      edges_q    <= '0;
      level_q    <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_reset_q <= 1'b0;
      // A strobe landing in the CFG cycle re-arms the request with the newer value.
      if (cfg_mask_wr) begin
        mask_q     <= cfg_mask;
        cfg_pend_q <= 1'b1;
      end else if (state_q == CFG) begin
        cfg_pend_q <= 1'b0;
      end
      if (state_q == RD_EDGE_S) edges_q <= pio_readdata[WIDTH-1:0];
      if (state_q == RD_DAT_S)  level_q <= pio_readdata[WIDTH-1:0];
      if (state_q == PUSH)      hold_cnt_q <= HW'(HOLDOFF_CYCLES - 1);
      else if (state_q == HOLD) hold_cnt_q <= hold_cnt_q - 1'b1;
    end
  end

  assign push_req = (state_q == PUSH) && !in_reset_q && (edges_q != '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign do_pop   = evt_valid && evt_ready;
  assign do_push  = push_req && (!full || do_pop);
  assign drop     = push_req && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {level_q, edges_q};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_data  = mem_q[rd_ptr_q];
  assign evt_count = count_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_button_pio_irq_sequencer.sv
// Directed + randomized bench: a behavioural PIO slave and an event-queue
// scoreboard predict every bus cycle and FIFO result of the sequencer.
module tb_button_pio_irq_sequencer;
  localparam int W = 4;
  localparam int D = 8;
  localparam int H = 10;

  logic        clk = 1'b0;
  logic        reset_n, enable, cfg_mask_wr, evt_ready, ovf_clr;
  logic [3:0]  cfg_mask;
  logic        pio_irq;
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata = 32'h0;
  logic        evt_valid;
  logic [7:0]  evt_data;
  logic [3:0]  evt_count;
  logic        overflow, busy;

  // PIO slave model
  logic [3:0]  edge_cap = 4'h0;
  logic [3:0]  mask_m   = 4'h0;
  logic [3:0]  level, inject;
  logic        force_irq;

  // scoreboard
  logic [7:0]  q[$];
  bit          exp_ovf;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  button_pio_irq_sequencer #(
    .WIDTH(W), .DEPTH(D), .HOLDOFF_CYCLES(H), .MASK_INIT(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cfg_mask(cfg_mask), .cfg_mask_wr(cfg_mask_wr), .pio_irq(pio_irq),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .evt_count(evt_count), .overflow(overflow),
    .ovf_clr(ovf_clr), .busy(busy)
  );

  assign pio_irq = force_irq | (|(edge_cap & mask_m));

  always @(posedge clk) begin
    if (pio_chipselect && pio_write_n)
      pio_readdata <= (pio_address == 2'd3) ? {28'hA5A5A5A, edge_cap} :
                      (pio_address == 2'd0) ? {28'h5A5A5A5, level} : 32'h0;
    else
      pio_readdata <= 32'h0;
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3) edge_cap <= inject;
    else                                                        edge_cap <= edge_cap | inject;
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) mask_m <= pio_writedata[3:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_bus(input string tag, input logic cs, input logic wn, input logic [1:0] a);
    chk({tag, "_cs"}, pio_chipselect, cs);
    chk({tag, "_wn"}, pio_write_n, wn);
    chk({tag, "_addr"}, pio_address, a);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_bus(tag, 1'b0, 1'b1, 2'd0);
    chk({tag, "_wd"}, pio_writedata, 32'h0);
    chk({tag, "_valid"}, evt_valid, 1'b0);
    chk({tag, "_count"}, evt_count, 4'd0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
  endtask

  // Called with reset_n just raised; checks the two start-up writes.
  task automatic chk_init_seq(input string tag);
    tick();
    chk_bus({tag, "_init1"}, 1'b1, 1'b0, 2'd2);
    chk({tag, "_init1_wd"}, pio_writedata, 32'hF);
    chk({tag, "_init1_busy"}, busy, 1'b1);
    tick();
    chk_bus({tag, "_init2"}, 1'b1, 1'b0, 2'd3);
    tick();
    chk({tag, "_init_idle"}, busy, 1'b0);
    chk_bus({tag, "_init_idle"}, 1'b0, 1'b1, 2'd0);
  endtask

  // One complete irq service started from IDLE, checked cycle by cycle.
  task automatic service(input logic [3:0] e, input logic [3:0] lv, input bit spurious,
                         input bit pop_at_push, input bit cfg_in_hold, input logic [3:0] cfg_v);
    int   last;
    bit   pushes;
    logic ecs, ewn;
    logic [1:0] ea;
    string t;
    level = lv;
    if (spurious) force_irq = 1'b1;
    else begin
      inject = e;
      tick();
      inject = 4'h0;
    end
    chk("svc_start_idle", busy, 1'b0);
    pushes = !spurious;
    last   = pushes ? 8 + H : 7;
    for (int k = 1; k <= last; k++) begin
      tick();
      t = $sformatf("svc_k%0d", k);
      if (k == 1) force_irq = 1'b0;
      if (k == 7) begin
        if (pop_at_push) begin
          evt_ready = 1'b0;
          if (q.size() > 0) void'(q.pop_front());
        end
        if (pushes) begin
          if (q.size() < D) q.push_back({lv, e});
          else exp_ovf = 1'b1;
        end
      end
      ecs = 1'b0; ewn = 1'b1; ea = 2'd0;
      if (k == 1 || k == 2)          begin ecs = 1'b1; ea = 2'd3; end
      else if (k == 3)               begin ecs = 1'b1; ewn = 1'b0; ea = 2'd3; end
      else if (k == 4 || k == 5)     begin ecs = 1'b1; ea = 2'd0; end
      else if (pushes && k == 7 + H) begin ecs = 1'b1; ewn = 1'b0; ea = 2'd3; end
      chk_bus(t, ecs, ewn, ea);
      if (ewn) chk({t, "_wd"}, pio_writedata, 32'h0);
      else     chk({t, "_wd_hi"}, pio_writedata[31:4], 28'h0);
      chk({t, "_busy"}, busy, (k != last));
      if (k == 7) begin
        chk({t, "_count"}, evt_count, q.size());
        chk({t, "_valid"}, evt_valid, (q.size() != 0));
        if (q.size() > 0) chk({t, "_head"}, evt_data, q[0]);
        chk({t, "_ovf"}, overflow, exp_ovf);
      end
      if (k == 6 && pop_at_push) evt_ready = 1'b1;
      if (cfg_in_hold) begin
        if (k == 10) begin cfg_mask = 4'hA; cfg_mask_wr = 1'b1; force_irq = 1'b1; end
        if (k == 11) cfg_mask = cfg_v;
        if (k == 12) cfg_mask_wr = 1'b0;
      end
    end
  endtask

  task automatic pop_one();
    chk("pop_valid", evt_valid, 1'b1);
    chk("pop_head", evt_data, q[0]);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    void'(q.pop_front());
    chk("pop_count", evt_count, q.size());
  endtask

  task automatic drain();
    while (q.size() > 0) pop_one();
    chk("drain_valid", evt_valid, 1'b0);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy; i++) tick();
    chk("wait_idle", busy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; cfg_mask = 4'h0; cfg_mask_wr = 1'b0;
    evt_ready = 1'b0; ovf_clr = 1'b0; level = 4'h0; inject = 4'h0;
    force_irq = 1'b0; exp_ovf = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    chk_init_seq("boot");

    // Directed event: edges 0x2, level 0xD
    service(4'h2, 4'hD, 1'b0, 1'b0, 1'b0, 4'h0);
    drain();

    // Pop while empty is ignored
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("empty_pop_count", evt_count, 4'd0);

    // Spurious irq: no push, no hold-off
    service(4'h0, 4'h3, 1'b1, 1'b0, 1'b0, 4'h0);

    // Randomized events with random partial draining
    for (int n = 0; n < 6; n++) begin
      service(4'($urandom_range(1, 15)), 4'($urandom), 1'b0, 1'b0, 1'b0, 4'h0);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) pop_one();
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();

    // Overflow: nine events into an eight-deep FIFO
    for (int n = 0; n < 9; n++)
      service(4'($urandom_range(1, 15)), 4'($urandom), 1'b0, 1'b0, 1'b0, 4'h0);
    chk("ovf_count", evt_count, 4'd8);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_head", evt_data, q[0]);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    // Push with simultaneous pop while full
    service(4'($urandom_range(1, 15)), 4'($urandom), 1'b0, 1'b1, 1'b0, 4'h0);
    chk("full_pushpop_count", evt_count, 4'd8);
    drain();

    // Config strobes during HOLD with irq pending: CFG (last value) runs first
    service(4'h1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h5);
    tick();
    chk_bus("cfg_write", 1'b1, 1'b0, 2'd2);
    chk("cfg_write_wd", pio_writedata, 32'h5);
    tick();
    chk("cfg_back_idle", busy, 1'b0);
    tick();
    chk_bus("cfg_then_rd_edge", 1'b1, 1'b1, 2'd3);
    force_irq = 1'b0;
    wait_idle(20);

    // enable=0 ignores irq; then reset in the middle of RD_DAT
    enable = 1'b0;
    inject = 4'h1;
    tick();
    inject = 4'h0;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("disabled_idle%0d", n), busy, 1'b0);
      tick();
    end
    enable = 1'b1;
    tick();
    chk_bus("en_rd_edge", 1'b1, 1'b1, 2'd3);
    repeat (3) tick();
    chk_bus("en_rd_dat", 1'b1, 1'b1, 2'd0);
    chk("pre_reset_count", evt_count, q.size());
    reset_n = 1'b0;
    tick();
    chk_reset_vals("midrst");
    q.delete();
    reset_n = 1'b1;
    chk_init_seq("reboot");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
